// File: rtl/bus_arb_pkg.sv
// Shared types and default widths for the round-robin bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam int ARB_ADDR_W = 8;
   localparam int ARB_DATA_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr,
// otherwise lowest requester overall (the wrap-around case).
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               any
);

   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] upper_req;

   function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
      return v & (~v + NUM_REQ'(1));
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
         assign upper_mask[gi] = (PTR_W'(gi) >= ptr);
      end
   endgenerate

   assign upper_req = req_valid & upper_mask;
   assign any       = |req_valid;
   assign winner    = (|upper_req) ? lowest_set(upper_req) : lowest_set(req_valid);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that issues one latched command per transaction onto a
// shared bus and returns read data to the winning requester.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_W     = ARB_ADDR_W,
   parameter int DATA_W     = ARB_DATA_W,
   parameter int RD_LATENCY = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_read,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      busy,
   output logic                      read,
   output logic                      enable,
   output logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         data
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(RD_LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

   generate
      if (RD_LATENCY < 1) begin : g_bad_latency
         $error("bus_arbiter: RD_LATENCY must be at least 1");
      end
      if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
         $error("bus_arbiter: NUM_REQ must be in 2..8");
      end
   endgenerate

   arb_state_e          state_reg, state_next;
   logic [PTR_W-1:0]    ptr_reg, ptr_next;
   logic [NUM_REQ-1:0]  win_reg, win_next;
   logic [PTR_W-1:0]    win_idx_reg, win_idx_next;
   logic                rd_reg, rd_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
   logic [NUM_REQ-1:0]  rsp_valid_reg, rsp_valid_next;
   logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
   logic                busy_reg, busy_next;
   logic                read_reg, read_next;
   logic                enable_reg, enable_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;

   logic [NUM_REQ-1:0]  pick_onehot;
   logic                pick_any;
   logic [PTR_W-1:0]    pick_idx;
   logic                pick_read;
   logic [ADDR_W-1:0]   pick_addr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr_reg),
      .winner    (pick_onehot),
      .any       (pick_any)
   );

   always_comb begin
      pick_idx  = '0;
      pick_read = 1'b0;
      pick_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_onehot[i]) begin
            pick_idx  = PTR_W'(i);
            pick_read = req_read[i];
            pick_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Bus strobes default low so they are only ever high for the single ISSUE cycle.
   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      win_next       = win_reg;
      win_idx_next   = win_idx_reg;
      rd_next        = rd_reg;
      cnt_next       = cnt_reg;
      gnt_next       = '0;
      rsp_valid_next = '0;
      rsp_data_next  = rsp_data_reg;
      read_next      = 1'b0;
      enable_next    = 1'b0;
      addr_next      = '0;

      unique case (state_reg)
         IDLE: begin
            if (pick_any) begin
               win_next     = pick_onehot;
               win_idx_next = pick_idx;
               rd_next      = pick_read;
               gnt_next     = pick_onehot;
               enable_next  = 1'b1;
               read_next    = pick_read;
               addr_next    = pick_addr;
               state_next   = ISSUE;
            end
         end
         ISSUE: begin
            ptr_next = (win_idx_reg == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_reg + PTR_W'(1);
            if (rd_reg) begin
               cnt_next   = CNT_LOAD;
               state_next = WAIT;
            end else begin
               rsp_valid_next = win_reg;
               rsp_data_next  = '0;
               state_next     = RESP;
            end
         end
         WAIT: begin
            if (cnt_reg == '0) begin
               rsp_data_next  = data;
               rsp_valid_next = win_reg;
               state_next     = RESP;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         win_reg       <= '0;
         win_idx_reg   <= '0;
         rd_reg        <= 1'b0;
         cnt_reg       <= '0;
         gnt_reg       <= '0;
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
         busy_reg      <= 1'b0;
         read_reg      <= 1'b0;
         enable_reg    <= 1'b0;
         addr_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         win_reg       <= win_next;
         win_idx_reg   <= win_idx_next;
         rd_reg        <= rd_next;
         cnt_reg       <= cnt_next;
         gnt_reg       <= gnt_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_data_reg  <= rsp_data_next;
         busy_reg      <= busy_next;
         read_reg      <= read_next;
         enable_reg    <= enable_next;
         addr_reg      <= addr_next;
      end
   end

   assign gnt       = gnt_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign busy      = busy_reg;
   assign read      = read_reg;
   assign enable    = enable_reg;
   assign addr      = addr_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-timeline reference model.
module tb_bus_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int L  = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_read;
   logic [N*AW-1:0]   req_addr;
   logic [N-1:0]      gnt;
   logic [N-1:0]      rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              busy;
   logic              read;
   logic              enable;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     data;

   bus_arbiter #(
      .NUM_REQ    (N),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RD_LATENCY (L)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_read  (req_read),
      .req_addr  (req_addr),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .read      (read),
      .enable    (enable),
      .addr      (addr),
      .data      (data)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;
   int n_txn    = 0;

   // Reference model: one scheduled transaction described by its cycle numbers.
   int            m_ptr   = 0;
   int            m_free  = 0;
   int            m_issue = -1;
   int            m_resp  = -1;
   int            m_cap   = -1;
   int            m_win   = 0;
   logic          m_rd    = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_rsp_data = '0;
   logic          m_rst_now  = 1'b0;
   int            force_cap  = -1;
   int            obs_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic model_edge();
      int e;
      int w;
      bit found;
      e = edge_n;
      m_rst_now = reset;
      if (reset) begin
         m_ptr = 0; m_free = e + 1;
         m_issue = -1; m_resp = -1; m_cap = -1;
         m_rsp_data = '0;
      end else begin
         if (e == m_cap) m_rsp_data = data;
         if (e == m_issue && !m_rd) m_rsp_data = '0;
         if (e >= m_free && req_valid != '0) begin
            found = 0; w = 0;
            for (int k = 0; k < N; k++) begin
               int idx;
               idx = (m_ptr + k) % N;
               if (!found && req_valid[idx]) begin
                  found = 1; w = idx;
               end
            end
            m_win   = w;
            m_rd    = req_read[w];
            m_addr  = req_addr[w*AW +: AW];
            m_issue = e + 1;
            m_ptr   = (w + 1) % N;
            if (m_rd) begin
               m_cap  = e + 1 + L;
               m_resp = e + 2 + L;
            end else begin
               m_cap  = -1;
               m_resp = e + 2;
            end
            m_free = m_resp + 1;
         end
      end
   endtask

   task automatic compare_outputs();
      int c;
      bit en;
      logic [N-1:0] oh;
      c  = edge_n;
      en = (c == m_issue);
      oh = N'(1) << m_win;
      check("gnt",       32'(gnt),       en ? 32'(oh) : 32'(0));
      check("enable",    32'(enable),    32'(en));
      check("read",      32'(read),      32'(en && m_rd));
      check("addr",      32'(addr),      en ? 32'(m_addr) : 32'(0));
      check("rsp_valid", 32'(rsp_valid), (c == m_resp) ? 32'(oh) : 32'(0));
      check("busy",      32'(busy),      32'(m_issue >= 0 && c >= m_issue && c <= m_resp));
      if (c == m_resp || m_rst_now)
         check("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
      for (int i = 0; i < N; i++)
         if (gnt[i]) obs_q.push_back(i);
      if (c == m_resp) begin
         n_txn++;
         $display("txn %0d: req=%0d %s addr=0x%02h rsp_data=0x%02h", n_txn, m_win,
                  m_rd ? "read " : "write", m_addr, rsp_data);
      end
   endtask

   task automatic step();
      @(negedge clock);
      if (force_cap >= 0 && m_cap == edge_n) data = DW'(force_cap);
      else data = DW'($urandom);
      @(posedge clock);
      model_edge();
      edge_n++;
      #1;
      compare_outputs();
   endtask

   task automatic idle(input int cycles);
      req_valid = '0;
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic wait_gnt(input int budget, output int idx);
      idx = -1;
      for (int i = 0; i < budget && idx < 0; i++) begin
         step();
         for (int j = 0; j < N; j++) if (gnt[j]) idx = j;
      end
      check("gnt_seen", 32'(gnt != '0), 32'(1));
   endtask

   initial begin
      int idx;
      int cnt;
      reset = 1'b1; req_valid = '0; req_read = '0; req_addr = '0; data = '0;

      // Reset held with random requests: everything stays at zero.
      for (int i = 0; i < 3; i++) begin
         req_valid = N'($urandom); req_read = N'($urandom); req_addr = (N*AW)'($urandom);
         step();
      end

      // Release with all requesting: grants run 0,1,2,3,0,1,2,3.
      obs_q.delete();
      reset = 1'b0; req_valid = '1;
      wait_gnt(10, idx);
      check("first_gnt_after_reset", 32'(idx), 32'(0));
      for (int i = 0; i < 100 && obs_q.size() < 8; i++) begin
         req_read = N'($urandom); req_addr = (N*AW)'($urandom);
         step();
      end
      check("rr_count", 32'(obs_q.size()), 32'(8));
      for (int k = 0; k < obs_q.size() && k < 8; k++)
         check("rr_order", 32'(obs_q[k]), 32'(k % N));
      idle(10);

      // Single read from requester 2.
      req_valid = 4'b0100; req_read = 4'b0100; req_addr[2*AW +: AW] = 8'h5A; force_cap = 8'hC3;
      step();
      check("rd_gnt", 32'(gnt), 32'(4'b0100));
      check("rd_enable", 32'(enable), 32'(1));
      check("rd_read", 32'(read), 32'(1));
      check("rd_addr", 32'(addr), 32'(8'h5A));
      req_valid = '0;
      step(); step(); step();
      check("rd_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
      check("rd_rsp_data", 32'(rsp_data), 32'(8'hC3));
      force_cap = -1;
      idle(6);

      // Non-read from requester 1.
      req_valid = 4'b0010; req_read = 4'b0000; req_addr[1*AW +: AW] = 8'h10;
      step();
      check("wr_enable", 32'(enable), 32'(1));
      check("wr_read", 32'(read), 32'(0));
      check("wr_gnt", 32'(gnt), 32'(4'b0010));
      req_valid = '0;
      step();
      check("wr_enable_drop", 32'(enable), 32'(0));
      check("wr_rsp_valid", 32'(rsp_valid), 32'(4'b0010));
      check("wr_rsp_data", 32'(rsp_data), 32'(0));
      idle(6);

      // Requester 0 changes its address after the latch; requester 3 withdraws while busy.
      req_valid = 4'b0001; req_read = 4'b0001; req_addr[0 +: AW] = 8'h20;
      step();
      req_addr[0 +: AW] = 8'hEE; req_valid = 4'b1001;
      check("latched_addr", 32'(addr), 32'(8'h20));
      check("latched_gnt", 32'(gnt), 32'(4'b0001));
      step();
      req_valid = '0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (gnt[3]) cnt++;
      end
      check("withdrawn_gnt3", 32'(cnt), 32'(0));

      // Reset during WAIT abandons the read and restarts arbitration at 0.
      req_valid = 4'b0100; req_read = 4'b0100; req_addr[2*AW +: AW] = 8'h33;
      step();
      req_valid = '0;
      step();
      check("mid_busy", 32'(busy), 32'(1));
      reset = 1'b1;
      step();
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_enable", 32'(enable), 32'(0));
      reset = 1'b0; req_valid = '1;
      wait_gnt(10, idx);
      check("gnt_after_mid_reset", 32'(idx), 32'(0));
      req_valid = '0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (rsp_valid[2]) cnt++;
      end
      check("abandoned_rsp", 32'(cnt), 32'(0));

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         req_valid = N'($urandom); req_read = N'($urandom); req_addr = (N*AW)'($urandom);
         reset = ($urandom_range(0, 63) == 0);
         step();
      end
      reset = 1'b0;
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
